// File: rtl/pmu_regfile_arbiter_pkg.sv
// Shared types and helpers for the PMU register-bank arbiter.
package pmu_pkg;

  typedef enum logic {ARB, LOCKED} pmu_arb_state_e;

  // Per-requester control fields unpacked from the flattened request ports.
  typedef struct packed {
    logic req;
    logic we;
    logic lock;
  } pmu_req_ctl_t;

  function automatic int pmu_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmu_regfile_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 (wrapping) for the first
// eligible request, optionally restricted to a single owner.
module pmu_rr_pick
  import pmu_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IDX_W = pmu_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             owner_en_i,
  input  logic [N_REQ-1:0] owner_mask_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [N_REQ-1:0] eligible;

  always_comb begin
    eligible = owner_en_i ? (req_i & owner_mask_i) : req_i;
    gnt_o    = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int c;
      c = (int'(ptr_i) + i) % N_REQ;
      if (!vld_o && eligible[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/pmu_regfile_arbiter.sv
// Round-robin arbiter sharing the single-port PMU register bank between requesters,
// with a bounded exclusive lock and registered read/error responses.
module pmu_regfile_arbiter
  import pmu_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int N_REGS    = 20,
  parameter int REG_WIDTH = 32,
  parameter int LOCK_MAX  = 8,
  localparam int ADDR_W   = $clog2(N_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           we_i,
  input  logic [N_REQ-1:0]           lock_i,
  input  logic [N_REQ*ADDR_W-1:0]    addr_i,
  input  logic [N_REQ*REG_WIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           rvalid_o,
  output logic [N_REQ-1:0]           err_o,
  output logic [REG_WIDTH-1:0]       rdata_o,
  output logic                       rf_we_o,
  output logic [ADDR_W-1:0]          rf_addr_o,
  output logic [REG_WIDTH-1:0]       rf_wdata_o,
  input  logic [REG_WIDTH-1:0]       rf_rdata_i
);

  localparam int IDX_W = pmu_idx_w(N_REQ);
  localparam int CNT_W = pmu_idx_w(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  pmu_arb_state_e       state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]     rvalid_q, rvalid_d;
  logic [N_REQ-1:0]     err_q, err_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;

  pmu_req_ctl_t         ctl [N_REQ];
  logic [N_REQ-1:0]     req_vec;
  logic [N_REQ-1:0]     owner_mask;
  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [N_REQ-1:0]     gnt;
  logic                 gnt_any;
  logic                 win_we;
  logic                 win_lock;
  logic                 win_oor;
  logic [ADDR_W-1:0]    win_addr;
  logic [REG_WIDTH-1:0] win_wdata;
  logic                 owner_lock;

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      ctl[k]     = '{req: req_i[k], we: we_i[k], lock: lock_i[k]};
      req_vec[k] = ctl[k].req;
    end
  end

  pmu_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i        (req_vec),
    .ptr_i        (ptr_q),
    .owner_en_i   (state_q == LOCKED),
    .owner_mask_i (owner_mask),
    .gnt_o        (pick_gnt),
    .idx_o        (pick_idx),
    .vld_o        (pick_vld)
  );

  // Grants are suppressed during reset so the bank port stays idle.
  assign gnt     = rst_i ? '0 : pick_gnt;
  assign gnt_any = |gnt;

  always_comb begin
    win_we     = 1'b0;
    win_lock   = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    owner_lock = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        win_we    = ctl[k].we;
        win_lock  = ctl[k].lock;
        win_addr  = addr_i[k*ADDR_W +: ADDR_W];
        win_wdata = wdata_i[k*REG_WIDTH +: REG_WIDTH];
      end
      if (owner_mask[k]) owner_lock = ctl[k].lock;
    end
    win_oor = (32'(win_addr) >= N_REGS);
  end

  assign rf_we_o    = gnt_any && win_we && !win_oor;
  assign rf_addr_o  = win_addr;
  assign rf_wdata_o = win_wdata;

  always_comb begin
    rvalid_d = gnt & {N_REQ{~win_we}};
    err_d    = gnt & {N_REQ{win_oor}};
    rdata_d  = (gnt_any && !win_we && !win_oor) ? rf_rdata_i : '0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (pick_vld) ptr_d = pick_idx;
    case (state_q)
      ARB: begin
        if (pick_vld && win_lock) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      LOCKED: begin
        cnt_d = cnt_q + 1'b1;
        // Release on owner drop or when the exclusive window is used up;
        // the owner becomes lowest priority for the next arbitration.
        if (!owner_lock || (cnt_q == CNT_LAST)) begin
          state_d = ARB;
          cnt_d   = '0;
          ptr_d   = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      ptr_q    <= IDX_W'(N_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_pmu_regfile_arbiter.sv
// Directed bench for pmu_regfile_arbiter with a behavioural 32-entry register bank.
module tb_pmu_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, we, lock;
  logic [14:0] addr;
  logic [95:0] wdata;
  logic [2:0]  gnt, rvalid, err;
  logic [31:0] rdata;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata;
  logic [31:0] bank [32];

  int errors = 0;
  int checks = 0;

  pmu_regfile_arbiter #(
    .N_REQ(3), .N_REGS(20), .REG_WIDTH(32), .LOCK_MAX(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .err_o(err), .rdata_o(rdata), .rf_we_o(rf_we), .rf_addr_o(rf_addr),
    .rf_wdata_o(rf_wdata), .rf_rdata_i(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: entry i resets to 0x1000_0000 + i; entries 20..31 exist only to
  // detect stray writes and unmasked read data.
  assign rf_rdata = bank[rf_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'h1000_0000 + 32'(i);
    end else if (rf_we) begin
      bank[rf_addr] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic l,
                       input logic [4:0] a, input logic [31:0] d);
    req[k]            = r;
    we[k]             = w;
    lock[k]           = l;
    addr[k*5 +: 5]    = a;
    wdata[k*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    drive(0, 1, 0, 0, 5'd0, 32'h0);
    drive(1, 1, 0, 0, 5'd1, 32'h0);
    drive(2, 1, 0, 0, 5'd2, 32'h0);

    // Reset behaviour
    tick(); settle();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_addr", rf_addr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'h0);
    tick();
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_err", err, 3'b000);
    chk("rst_rdata", rdata, 32'h0);

    // Round-robin rotation, all reading
    rst = 1'b0; settle();
    chk("rr_gnt0", gnt, 3'b001);
    chk("rr_addr0", rf_addr, 5'd0);
    tick();
    chk("rr_rv0", rvalid, 3'b001);
    chk("rr_rd0", rdata, 32'h1000_0000);
    settle();
    chk("rr_gnt1", gnt, 3'b010);
    chk("rr_addr1", rf_addr, 5'd1);
    tick();
    chk("rr_rv1", rvalid, 3'b010);
    chk("rr_rd1", rdata, 32'h1000_0001);
    chk("rr_gnt2", gnt, 3'b100);
    tick();
    chk("rr_rv2", rvalid, 3'b100);
    chk("rr_rd2", rdata, 32'h1000_0002);
    chk("rr_gnt_wrap", gnt, 3'b001);
    tick();
    chk("rr_rv3", rvalid, 3'b001);
    chk("rr_rd3", rdata, 32'h1000_0000);

    // Write then read from another requester
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    drive(2, 0, 0, 0, 5'd0, 32'h0);
    drive(1, 1, 1, 0, 5'd5, 32'hDEAD_BEEF);
    settle();
    chk("wr_gnt", gnt, 3'b010);
    chk("wr_rf_we", rf_we, 1'b1);
    chk("wr_rf_addr", rf_addr, 5'd5);
    chk("wr_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    drive(0, 1, 0, 0, 5'd5, 32'h0);
    settle();
    chk("wr_no_rvalid", rvalid, 3'b000);
    chk("war_gnt", gnt, 3'b001);
    tick();
    chk("war_rvalid", rvalid, 3'b001);
    chk("war_rdata", rdata, 32'hDEAD_BEEF);

    // Out-of-range read and write
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    drive(2, 1, 0, 0, 5'd20, 32'h0);
    settle();
    chk("oor_rd_gnt", gnt, 3'b100);
    chk("oor_rd_we", rf_we, 1'b0);
    tick();
    chk("oor_rd_err", err, 3'b100);
    chk("oor_rd_rvalid", rvalid, 3'b100);
    chk("oor_rd_rdata", rdata, 32'h0);
    drive(2, 1, 1, 0, 5'd31, 32'h1234_5678);
    settle();
    chk("oor_wr_gnt", gnt, 3'b100);
    chk("oor_wr_we", rf_we, 1'b0);
    tick();
    chk("oor_wr_err", err, 3'b100);
    chk("oor_wr_rvalid", rvalid, 3'b000);
    chk("oor_wr_bank", bank[31], 32'h1000_001F);

    // Bounded lock: requester 0 gets exactly 8 consecutive grants
    drive(0, 1, 0, 1, 5'd3, 32'h0);
    drive(1, 1, 0, 0, 5'd1, 32'h0);
    drive(2, 1, 0, 0, 5'd2, 32'h0);
    settle();
    chk("lk_gnt_c0", gnt, 3'b001);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (i == 1) begin
        chk("lk_rv", rvalid, 3'b001);
        chk("lk_rd", rdata, 32'h1000_0003);
      end
      settle();
      chk($sformatf("lk_gnt_c%0d", i), gnt, 3'b001);
    end
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    settle();
    chk("lk_after_1", gnt, 3'b010);
    tick();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    settle();
    chk("lk_after_2", gnt, 3'b100);
    tick();
    drive(2, 0, 0, 0, 5'd0, 32'h0);

    // Lock released early by owner dropping lock_i; idle owner still stalls others
    drive(1, 1, 0, 1, 5'd1, 32'h0);
    settle();
    chk("ld_gnt_enter", gnt, 3'b010);
    tick();
    drive(1, 0, 0, 1, 5'd1, 32'h0);
    drive(0, 1, 0, 0, 5'd0, 32'h0);
    drive(2, 1, 0, 0, 5'd2, 32'h0);
    settle();
    chk("ld_stall", gnt, 3'b000);
    tick();
    drive(1, 1, 0, 1, 5'd1, 32'h0);
    settle();
    chk("ld_gnt_hold", gnt, 3'b010);
    tick();
    drive(1, 1, 0, 0, 5'd1, 32'h0);
    settle();
    chk("ld_gnt_drop", gnt, 3'b010);
    tick();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    settle();
    chk("ld_next_2", gnt, 3'b100);
    tick();
    drive(2, 0, 0, 0, 5'd0, 32'h0);
    settle();
    chk("ld_next_0", gnt, 3'b001);
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0);

    // Reset while locked with a read response on the outputs
    drive(1, 1, 0, 1, 5'd4, 32'h0);
    settle();
    chk("rl_gnt", gnt, 3'b010);
    tick();
    chk("rl_pending_rv", rvalid, 3'b010);
    chk("rl_pending_rd", rdata, 32'h1000_0004);
    rst = 1'b1;
    settle();
    chk("rl_rst_gnt", gnt, 3'b000);
    tick();
    chk("rl_rvalid", rvalid, 3'b000);
    chk("rl_err", err, 3'b000);
    chk("rl_rdata", rdata, 32'h0);
    chk("rl_gnt_after", gnt, 3'b000);
    chk("rl_rf_we", rf_we, 1'b0);
    chk("rl_rf_addr", rf_addr, 5'd0);
    rst = 1'b0;
    drive(0, 1, 0, 0, 5'd6, 32'h0);
    drive(1, 1, 0, 0, 5'd4, 32'h0);
    drive(2, 1, 0, 0, 5'd2, 32'h0);
    settle();
    chk("rl_prio0", gnt, 3'b001);
    tick();
    chk("rl_rv", rvalid, 3'b001);
    chk("rl_rd", rdata, 32'h1000_0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
